// File: rtl/video_timing_monitor_if.sv
// Pixel-stream timing signals (hs/vs/de from dvi2rgb) together with the
// monitor's measurement and lock results.
interface video_timing_monitor_if;
  logic        hs_i;
  logic        vs_i;
  logic        de_i;
  logic [11:0] h_active_o;
  logic [11:0] h_total_o;
  logic [10:0] v_active_o;
  logic        frame_stb_o;
  logic        good_o;
  logic        locked_o;

  // master: the video source, which also observes the results
  modport master (
    output hs_i, vs_i, de_i,
    input  h_active_o, h_total_o, v_active_o, frame_stb_o, good_o, locked_o
  );

  // slave: the monitor, which watches the stream and reports
  modport slave (
    input  hs_i, vs_i, de_i,
    output h_active_o, h_total_o, v_active_o, frame_stb_o, good_o, locked_o
  );
endinterface

// File: rtl/video_timing_monitor.sv
// Passive timing monitor for the HDMI-in pixel stream. It measures line
// period, active width and active height of each frame and raises locked_o
// once LOCK_FRAMES consecutive frames match the configured timing.
// Pixel data is never touched.
module video_timing_monitor #(
  parameter int H_WIDTH       = 1920,
  parameter int H_TOTAL       = 2200,
  parameter int V_HEIGHT      = 1080,
  parameter int LOCK_FRAMES   = 4,
  parameter int FRAME_TIMEOUT = 3000000
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  video_timing_monitor_if.slave vif
);

  localparam logic [11:0] LP_HW = 12'(H_WIDTH);
  localparam logic [11:0] LP_HT = 12'(H_TOTAL);
  localparam logic [10:0] LP_VH = 11'(V_HEIGHT);
  localparam logic [3:0]  LP_LF = 4'(LOCK_FRAMES);
  localparam logic [21:0] LP_TO = 22'(FRAME_TIMEOUT);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t      r_state, w_state_n;
  logic        r_hs, r_vs, r_de, r_hs_d, r_vs_d, r_de_d;
  logic        r_hs_rise, r_vs_rise, r_de_fall, r_de_p;
  logic [11:0] r_hcnt, r_acnt, r_period, r_last_act;
  logic [10:0] r_vcnt;
  logic        r_bad;
  logic [21:0] r_tcnt;
  logic [3:0]  r_gcnt, w_gcnt_n, w_gcnt_inc;
  logic        r_good, r_locked, w_good_n, w_locked_n;
  logic [11:0] r_h_active, r_h_total;
  logic [10:0] r_v_active;
  logic        r_stb;

  logic [11:0] w_period, w_period_cl, w_act_cl;
  logic [10:0] w_vcnt_cl;
  logic        w_line_bad, w_act_bad, w_bad_cl, w_frame_good, w_timeout;

  // input stage plus a delayed copy for edge detection
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      {r_hs, r_vs, r_de}       <= '0;
      {r_hs_d, r_vs_d, r_de_d} <= '0;
    end else begin
      {r_hs, r_vs, r_de}       <= {vif.hs_i, vif.vs_i, vif.de_i};
      {r_hs_d, r_vs_d, r_de_d} <= {r_hs, r_vs, r_de};
    end

  // registered edge pulses; r_de_p is the de level aligned with them
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      {r_hs_rise, r_vs_rise, r_de_fall, r_de_p} <= '0;
    end else begin
      r_hs_rise <= r_hs & ~r_hs_d;
      r_vs_rise <= r_vs & ~r_vs_d;
      r_de_fall <= ~r_de & r_de_d;
      r_de_p    <= r_de;
    end

  // Line/frame close values. A line or de closing in the same cycle as the
  // vs edge is folded in here so it belongs to the frame being closed.
  always_comb begin
    w_period     = (r_hcnt == 12'hFFF) ? 12'hFFF : r_hcnt + 12'd1;
    w_line_bad   = r_hs_rise && (w_period != LP_HT);
    w_act_bad    = r_de_fall && (r_acnt != LP_HW);
    w_period_cl  = r_hs_rise ? w_period : r_period;
    w_act_cl     = r_de_fall ? r_acnt : r_last_act;
    w_vcnt_cl    = (r_de_fall && r_vcnt != 11'h7FF) ? r_vcnt + 11'd1 : r_vcnt;
    w_bad_cl     = r_bad | w_line_bad | w_act_bad | (r_vs_rise & r_de_p);
    w_frame_good = !w_bad_cl && (w_vcnt_cl == LP_VH);
    w_timeout    = !r_vs_rise && (r_tcnt >= LP_TO);
  end

  // horizontal, active, vertical and timeout counters plus sticky bad flag
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_hcnt     <= '0;
      r_period   <= '0;
      r_acnt     <= '0;
      r_last_act <= '0;
      r_vcnt     <= '0;
      r_bad      <= 1'b0;
      r_tcnt     <= '0;
    end else begin
      if (r_hs_rise)                r_hcnt <= '0;
      else if (r_hcnt != 12'hFFF)   r_hcnt <= r_hcnt + 12'd1;
      if (r_hs_rise)                r_period <= w_period;
      if (r_de_fall)                r_acnt <= '0;
      else if (r_de_p && r_acnt != 12'hFFF) r_acnt <= r_acnt + 12'd1;
      if (r_de_fall)                r_last_act <= r_acnt;
      r_vcnt <= r_vs_rise ? '0   : w_vcnt_cl;
      r_bad  <= r_vs_rise ? 1'b0 : w_bad_cl;
      if (r_vs_rise)                r_tcnt <= '0;
      else if (r_tcnt < LP_TO)      r_tcnt <= r_tcnt + 22'd1;
    end

  // latch measurements and pulse the strobe at each frame boundary
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_stb      <= 1'b0;
      r_h_active <= '0;
      r_h_total  <= '0;
      r_v_active <= '0;
    end else begin
      r_stb <= r_vs_rise;
      if (r_vs_rise) begin
        r_h_active <= w_act_cl;
        r_h_total  <= w_period_cl;
        r_v_active <= w_vcnt_cl;
      end
    end

  // lock FSM state register with registered good/locked flags
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_state  <= SEARCH;
      r_gcnt   <= '0;
      r_good   <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_gcnt   <= w_gcnt_n;
      r_good   <= w_good_n;
      r_locked <= w_locked_n;
    end

  // lock FSM next state; the timeout overrides any frame decision
  always_comb begin
    w_state_n  = r_state;
    w_gcnt_n   = r_gcnt;
    w_good_n   = r_good;
    w_locked_n = r_locked;
    w_gcnt_inc = r_gcnt + 4'd1;
    if (w_timeout) begin
      w_state_n  = SEARCH;
      w_gcnt_n   = '0;
      w_good_n   = 1'b0;
      w_locked_n = 1'b0;
    end else if (r_vs_rise) begin
      unique case (r_state)
        SEARCH: begin
          // the frame in progress started before we were watching
          w_state_n  = MEASURE;
          w_gcnt_n   = '0;
          w_good_n   = 1'b0;
          w_locked_n = 1'b0;
        end
        MEASURE: begin
          w_good_n = w_frame_good;
          if (!w_frame_good) begin
            w_gcnt_n = '0;
          end else begin
            w_gcnt_n = w_gcnt_inc;
            if (w_gcnt_inc >= LP_LF) begin
              w_state_n  = LOCKED;
              w_locked_n = 1'b1;
            end
          end
        end
        LOCKED: begin
          w_good_n = w_frame_good;
          if (!w_frame_good) begin
            w_state_n  = MEASURE;
            w_gcnt_n   = '0;
            w_locked_n = 1'b0;
          end
        end
        default: w_state_n = SEARCH;
      endcase
    end
  end

  assign vif.h_active_o  = r_h_active;
  assign vif.h_total_o   = r_h_total;
  assign vif.v_active_o  = r_v_active;
  assign vif.frame_stb_o = r_stb;
  assign vif.good_o      = r_good;
  assign vif.locked_o    = r_locked;

endmodule

// File: tb/tb_video_timing_monitor.sv
// Randomised frame stimulus for video_timing_monitor, checked against a
// frame-level model: each frame is described as a list of line lengths and
// de lengths, and the expected results follow from those lists directly.
module tb_video_timing_monitor;
  localparam int HW = 16, HT = 24, VH = 8, LF = 4, TO = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  video_timing_monitor_if vif();

  video_timing_monitor #(
    .H_WIDTH(HW), .H_TOTAL(HT), .V_HEIGHT(VH), .LOCK_FRAMES(LF), .FRAME_TIMEOUT(TO)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .vif   (vif)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // boundary snapshots and lock-fall time
  int          nstb = 0, snap_cyc = 0, fall_cyc = -1;
  logic [11:0] snap_hact, snap_htot;
  logic [10:0] snap_vact;
  logic        snap_good, snap_locked, prev_lk = 1'b0;
  always @(negedge clk) begin
    if (vif.frame_stb_o === 1'b1) begin
      nstb++;
      snap_cyc    = cyc;
      snap_hact   = vif.h_active_o;
      snap_htot   = vif.h_total_o;
      snap_vact   = vif.v_active_o;
      snap_good   = vif.good_o;
      snap_locked = vif.locked_o;
    end
    if (prev_lk && vif.locked_o === 1'b0) fall_cyc = cyc;
    prev_lk = (vif.locked_o === 1'b1);
  end

  // frame being driven (f_) and the one before it (p_)
  int f_nl, p_nl, p_len, nstb0, vs_cyc;
  int f_per[64], f_act[64], p_per[64], p_act[64];
  bit p_valid;

  // reference model state and expectations for the last closed frame
  bit          m_synced, m_locked;
  int          m_run, m_hact;
  logic [11:0] e_hact, e_htot;
  logic [10:0] e_vact;
  logic        e_good, e_locked;
  bit          e_meas_ok;

  task automatic model_reset();
    p_valid = 0; m_synced = 0; m_locked = 0; m_run = 0; m_hact = 0;
  endtask

  // Evaluate the previous frame: it is good when every line is H_TOTAL long,
  // every active line is H_WIDTH wide and there are V_HEIGHT active lines.
  // A frame longer than the timeout means the monitor lost sync during it.
  task automatic model_close();
    bit ok;
    int nact;
    ok = 1; nact = 0;
    e_meas_ok = p_valid;
    if (p_valid) begin
      for (int l = 0; l < p_nl; l++) begin
        if (p_per[l] != HT) ok = 0;
        if (p_act[l] > 0) begin
          nact++;
          m_hact = (p_act[l] > 4095) ? 4095 : p_act[l];
          if (p_act[l] != HW) ok = 0;
        end
      end
      if (nact != VH) ok = 0;
      e_hact = 12'(m_hact);
      e_htot = 12'((p_per[p_nl-1] > 4095) ? 4095 : p_per[p_nl-1]);
      e_vact = 11'(nact);
    end
    if (!p_valid || p_len > TO + 100) m_synced = 0;
    if (!m_synced) begin
      m_synced = 1; m_run = 0; m_locked = 0; e_good = 1'b0;
    end else begin
      e_good = ok;
      if (ok) begin
        m_run++;
        if (m_run >= LF) m_locked = 1;
      end else begin
        m_run = 0; m_locked = 0;
      end
    end
    e_locked = m_locked;
  endtask

  // kind: 0 good, 1 random bad de width, 2 random bad line period,
  // 3 one active line missing, 4 de width 15, 5 line period 25
  task automatic build_frame(input int kind);
    int l, d;
    f_nl = 10;
    for (int i = 0; i < f_nl; i++) begin
      f_per[i] = HT;
      f_act[i] = (i >= 2) ? HW : 0;
    end
    l = int'($urandom_range(2, 9));
    d = int'($urandom_range(1, 2));
    case (kind)
      1: f_act[l] = ($urandom_range(0, 1) != 0) ? HW + 1 : HW - 1;
      2: f_per[l-1] = ($urandom_range(0, 1) != 0) ? HT + d : HT - d;
      3: f_act[l] = 0;
      4: f_act[l] = 15;
      5: f_per[l-1] = 25;
      default: ;
    endcase
  endtask

  // Drive one frame: hs for 2 clocks at line start, vs over lines 0-1
  // (rising with line 0's hs), de from clock 4 for f_act clocks.
  task automatic run_frame();
    int len;
    len = 0;
    nstb0 = nstb;
    for (int l = 0; l < f_nl; l++)
      for (int c = 0; c < f_per[l]; c++) begin
        @(negedge clk);
        if (l == 0 && c == 0) vs_cyc = cyc;
        vif.hs_i = (c < 2);
        vif.vs_i = (l < 2);
        vif.de_i = (f_act[l] > 0) && (c >= 4) && (c < 4 + f_act[l]);
        len++;
      end
    model_close();
    p_nl = f_nl; p_len = len; p_valid = 1;
    for (int i = 0; i < f_nl; i++) begin
      p_per[i] = f_per[i];
      p_act[i] = f_act[i];
    end
  endtask

  task automatic test_reset();
    vif.hs_i = 1'b0; vif.vs_i = 1'b0; vif.de_i = 1'b0;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    n_vec++;
    if ({vif.h_active_o, vif.h_total_o, vif.v_active_o, vif.frame_stb_o, vif.good_o, vif.locked_o} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h/%h/%h stb=%b good=%b lock=%b, required all 0",
               vif.h_active_o, vif.h_total_o, vif.v_active_o, vif.frame_stb_o, vif.good_o, vif.locked_o);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    model_reset();
  endtask

  task automatic test_lock();
    for (int f = 1; f <= 6; f++) begin
      build_frame(0);
      run_frame();
      if (f == 1) begin
        n_vec++;
        if (snap_cyc - vs_cyc != 3) begin
          n_err++;
          $display("FAIL stb_latency: got %0d clocks, required 3", snap_cyc - vs_cyc);
        end
      end
      n_vec++;
      if (nstb - nstb0 != 1) begin n_err++; $display("FAIL lock stb_count f%0d: got %0d want 1", f, nstb - nstb0); end
      n_vec++;
      if (snap_good !== e_good) begin n_err++; $display("FAIL lock good f%0d: got %b want %b", f, snap_good, e_good); end
      n_vec++;
      if (snap_locked !== e_locked) begin n_err++; $display("FAIL lock locked f%0d: got %b want %b", f, snap_locked, e_locked); end
      if (e_meas_ok) begin
        n_vec++;
        if ({snap_hact, snap_htot, snap_vact} !== {e_hact, e_htot, e_vact}) begin
          n_err++;
          $display("FAIL lock meas f%0d: got %0d/%0d/%0d want %0d/%0d/%0d", f,
                   snap_hact, snap_htot, snap_vact, e_hact, e_htot, e_vact);
        end
      end
    end
  endtask

  task automatic test_bad_frames();
    int seq[$];
    seq = '{4, 0, 0, 0, 0, 3, 5};
    for (int i = 0; i < 14; i++) seq.push_back(($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
    foreach (seq[i]) begin
      build_frame(seq[i]);
      run_frame();
      n_vec++;
      if (nstb - nstb0 != 1) begin n_err++; $display("FAIL bad stb_count #%0d: got %0d want 1", i, nstb - nstb0); end
      n_vec++;
      if (snap_good !== e_good) begin n_err++; $display("FAIL bad good #%0d: got %b want %b", i, snap_good, e_good); end
      n_vec++;
      if (snap_locked !== e_locked) begin n_err++; $display("FAIL bad locked #%0d: got %b want %b", i, snap_locked, e_locked); end
      n_vec++;
      if ({snap_hact, snap_htot, snap_vact} !== {e_hact, e_htot, e_vact}) begin
        n_err++;
        $display("FAIL bad meas #%0d: got %0d/%0d/%0d want %0d/%0d/%0d", i,
                 snap_hact, snap_htot, snap_vact, e_hact, e_htot, e_vact);
      end
    end
  endtask

  // last line carries 5000 de clocks in a 5010-clock line
  task automatic test_saturation();
    for (int i = 0; i < 3; i++) begin
      build_frame(0);
      if (i == 0) begin f_per[9] = 5010; f_act[9] = 5000; end
      run_frame();
      n_vec++;
      if (snap_good !== e_good) begin n_err++; $display("FAIL sat good #%0d: got %b want %b", i, snap_good, e_good); end
      n_vec++;
      if (snap_locked !== e_locked) begin n_err++; $display("FAIL sat locked #%0d: got %b want %b", i, snap_locked, e_locked); end
      n_vec++;
      if ({snap_hact, snap_htot, snap_vact} !== {e_hact, e_htot, e_vact}) begin
        n_err++;
        $display("FAIL sat meas #%0d: got %0d/%0d/%0d want %0d/%0d/%0d", i,
                 snap_hact, snap_htot, snap_vact, e_hact, e_htot, e_vact);
      end
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 5; i++) begin
      build_frame(0);
      run_frame();
    end
    n_vec++;
    if (snap_locked !== 1'b1) begin n_err++; $display("FAIL to prelock: got %b want 1", snap_locked); end
    // 60 lines with vs only at the start: 1440 clocks between vs edges
    build_frame(0);
    f_nl = 60;
    for (int l = 10; l < 60; l++) begin f_per[l] = HT; f_act[l] = 0; end
    fall_cyc = -1;
    run_frame();
    n_vec++;
    if (fall_cyc - snap_cyc != TO + 1) begin
      n_err++;
      $display("FAIL to lock_fall: got %0d clocks after stb, required %0d", fall_cyc - snap_cyc, TO + 1);
    end
    n_vec++;
    if ({vif.good_o, vif.locked_o} !== 2'b00) begin
      n_err++;
      $display("FAIL to flags: got good=%b lock=%b, required 0/0", vif.good_o, vif.locked_o);
    end
    build_frame(0);
    run_frame();
    n_vec++;
    if ({snap_good, snap_locked} !== {e_good, e_locked}) begin
      n_err++;
      $display("FAIL to discard: got good=%b lock=%b want %b/%b", snap_good, snap_locked, e_good, e_locked);
    end
    n_vec++;
    if ({snap_hact, snap_htot, snap_vact} !== {e_hact, e_htot, e_vact}) begin
      n_err++;
      $display("FAIL to meas: got %0d/%0d/%0d want %0d/%0d/%0d",
               snap_hact, snap_htot, snap_vact, e_hact, e_htot, e_vact);
    end
  endtask

  task automatic test_reset_midline();
    for (int i = 0; i < 5; i++) begin
      build_frame(0);
      run_frame();
    end
    @(negedge clk); vif.hs_i = 1'b1; vif.vs_i = 1'b0; vif.de_i = 1'b0;
    repeat (2) @(negedge clk);
    vif.hs_i = 1'b0; vif.de_i = 1'b1;
    repeat (int'($urandom_range(3, 8))) @(negedge clk);
    n_vec++;
    if (vif.locked_o !== 1'b1) begin n_err++; $display("FAIL rst prelock: got %b want 1", vif.locked_o); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({vif.h_active_o, vif.h_total_o, vif.v_active_o, vif.frame_stb_o, vif.good_o, vif.locked_o} !== '0) begin
      n_err++;
      $display("FAIL rst async_clear: got %h/%h/%h stb=%b good=%b lock=%b, required all 0",
               vif.h_active_o, vif.h_total_o, vif.v_active_o, vif.frame_stb_o, vif.good_o, vif.locked_o);
    end
    vif.de_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int f = 1; f <= 6; f++) begin
      build_frame(0);
      run_frame();
      n_vec++;
      if (snap_locked !== e_locked) begin n_err++; $display("FAIL rst relock f%0d: got %b want %b", f, snap_locked, e_locked); end
      n_vec++;
      if (snap_good !== e_good) begin n_err++; $display("FAIL rst good f%0d: got %b want %b", f, snap_good, e_good); end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_bad_frames();
    test_saturation();
    test_timeout();
    test_reset_midline();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
